// File: rtl/branch_predictor_table_controller.sv
// Write-port sequencer for the branch predictor tag/target banks: runs the
// invalidation walk after reset or flush, and drains queued execute-stage updates.
module branch_predictor_table_controller #(
  parameter int ENTRIES    = 512,
  parameter int WAYS       = 2,
  parameter int ENTRY_W    = 24,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_W    = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_request,
  output logic               flush_done,
  output logic               table_ready,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [ADDR_W-1:0]  upd_addr,
  input  logic [WAYS-1:0]    upd_way,
  input  logic [ENTRY_W-1:0] upd_entry,
  input  logic               upd_target_en,
  input  logic [31:0]        upd_target,
  output logic [WAYS-1:0]    tag_we,
  output logic [WAYS-1:0]    target_we,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [ENTRY_W-1:0] wr_entry,
  output logic [31:0]        wr_target
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [WAYS-1:0]    way;
    logic [ENTRY_W-1:0] entry;
    logic               target_en;
    logic [31:0]        target;
  } upd_t;

  // Update handshake: an update transfers in a cycle where upd_valid and
  // upd_ready are both high; upd_ready only reflects the registered full flag.
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic                done_q, done_d;
  upd_t                mem_q [FIFO_DEPTH];
  upd_t                head;
  logic                empty, full, push, pop;

  assign empty = (rd_q == wr_q);
  assign full  = (rd_q[PTR_W-1] != wr_q[PTR_W-1]) &&
                 (rd_q[PTR_W-2:0] == wr_q[PTR_W-2:0]);
  assign head  = mem_q[rd_q[PTR_W-2:0]];

  // A push in the flush cycle is dropped along with the rest of the queue.
  assign push  = rst && upd_valid && !full && !flush_request;
  assign pop   = (state_q == RUN) && !empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    if (flush_request) begin
      state_d = CLEAR;
      cnt_d   = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (state_q == CLEAR) begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(ENTRIES - 1)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end else if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      if (push) begin
        wr_d = wr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q[PTR_W-2:0]] <= '{addr: upd_addr, way: upd_way, entry: upd_entry,
                                  target_en: upd_target_en, target: upd_target};
    end
  end

  // Everything is forced low while rst is asserted so the RAMs see no writes.
  assign flush_done  = rst && done_q;
  assign table_ready = rst && (state_q == RUN);
  assign upd_ready   = rst && !full;

  always_comb begin
    tag_we    = '0;
    target_we = '0;
    wr_addr   = '0;
    wr_entry  = '0;
    wr_target = '0;
    if (rst) begin
      if (state_q == CLEAR) begin
        tag_we  = '1;
        wr_addr = cnt_q;
      end else if (!empty) begin
        tag_we    = head.way;
        target_we = head.way & {WAYS{head.target_en}};
        wr_addr   = head.addr;
        wr_entry  = head.entry;
        wr_target = head.target;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table_controller.sv
// Bench for branch_predictor_table_controller: directed scenarios with literal
// expectations, then random traffic against a queue-based model checked every cycle.
module tb_branch_predictor_table_controller;

  localparam int ENTRIES    = 8;
  localparam int WAYS       = 2;
  localparam int ENTRY_W    = 24;
  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 3;
  localparam int UW         = ADDR_W + WAYS + ENTRY_W + 1 + 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [WAYS-1:0]    way;
    logic [ENTRY_W-1:0] entry;
    logic               ten;
    logic [31:0]        target;
  } upd_s;

  logic               clk, rst, flush_request, flush_done, table_ready;
  logic               upd_valid, upd_ready, upd_target_en;
  logic [ADDR_W-1:0]  upd_addr, wr_addr;
  logic [WAYS-1:0]    upd_way, tag_we, target_we;
  logic [ENTRY_W-1:0] upd_entry, wr_entry;
  logic [31:0]        upd_target, wr_target;

  branch_predictor_table_controller #(
    .ENTRIES(ENTRIES), .WAYS(WAYS), .ENTRY_W(ENTRY_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .flush_request(flush_request), .flush_done(flush_done),
    .table_ready(table_ready), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_way(upd_way), .upd_entry(upd_entry),
    .upd_target_en(upd_target_en), .upd_target(upd_target), .tag_we(tag_we),
    .target_we(target_we), .wr_addr(wr_addr), .wr_entry(wr_entry), .wr_target(wr_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: walk index (-1 once the table is usable) plus the pending-update queue.
  logic [UW-1:0] exp_q[$];
  int            m_walk = 0;
  logic          m_done = 1'b0;

  always @(negedge clk) begin
    logic [WAYS-1:0]    e_tag, e_tgt;
    logic [ADDR_W-1:0]  e_addr;
    logic [ENTRY_W-1:0] e_ent;
    logic [31:0]        e_wt;
    logic               e_tr, e_ur, e_done, acc;
    upd_s               h;
    e_tag = '0; e_tgt = '0; e_addr = '0; e_ent = '0; e_wt = '0;
    e_tr = 1'b0; e_ur = 1'b0; e_done = 1'b0;
    if (rst) begin
      e_ur   = (exp_q.size() < FIFO_DEPTH);
      e_done = m_done;
      if (m_walk >= 0) begin
        e_tag  = '1;
        e_addr = ADDR_W'(m_walk);
      end else begin
        e_tr = 1'b1;
        if (exp_q.size() > 0) begin
          h      = upd_s'(exp_q[0]);
          e_tag  = h.way;
          e_tgt  = h.way & {WAYS{h.ten}};
          e_addr = h.addr;
          e_ent  = h.entry;
          e_wt   = h.target;
        end
      end
    end
    check("m_tag_we",      64'(tag_we),      64'(e_tag));
    check("m_target_we",   64'(target_we),   64'(e_tgt));
    check("m_wr_addr",     64'(wr_addr),     64'(e_addr));
    check("m_wr_entry",    64'(wr_entry),    64'(e_ent));
    check("m_wr_target",   64'(wr_target),   64'(e_wt));
    check("m_table_ready", 64'(table_ready), 64'(e_tr));
    check("m_upd_ready",   64'(upd_ready),   64'(e_ur));
    check("m_flush_done",  64'(flush_done),  64'(e_done));

    if (!rst) begin
      m_walk = 0;
      exp_q.delete();
      m_done = 1'b0;
    end else begin
      acc = upd_valid && (exp_q.size() < FIFO_DEPTH);
      if (flush_request) begin
        m_walk = 0;
        exp_q.delete();
        m_done = 1'b0;
      end else begin
        if (m_walk >= 0) begin
          if (m_walk == ENTRIES - 1) begin
            m_walk = -1;
            m_done = 1'b1;
          end else begin
            m_walk++;
            m_done = 1'b0;
          end
        end else begin
          m_done = 1'b0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (acc) exp_q.push_back({upd_addr, upd_way, upd_entry, upd_target_en, upd_target});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input int a, input int w, input int t);
    upd_addr      = ADDR_W'(a);
    upd_way       = WAYS'(w);
    upd_entry     = ENTRY_W'($urandom);
    upd_target_en = 1'b1;
    upd_target    = 32'(t);
  endtask

  task automatic flush_pulse();
    step();
    flush_request = 1'b1;
    step();
    flush_request = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20 && !table_ready; k++) @(negedge clk);
    check("wait_table_ready", 64'(table_ready), 64'd1);
  endtask

  initial begin
    int acc;
    rst = 1'b0; flush_request = 1'b0; upd_valid = 1'b0;
    upd_addr = '0; upd_way = '0; upd_entry = '0; upd_target_en = 1'b0; upd_target = '0;

    // reset and initial walk
    repeat (3) step();
    @(negedge clk);
    check("rst_tag_we", 64'(tag_we), 64'd0);
    check("rst_upd_ready", 64'(upd_ready), 64'd0);
    check("rst_table_ready", 64'(table_ready), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      check("walk_tag_we", 64'(tag_we), 64'h3);
      check("walk_addr", 64'(wr_addr), 64'(i));
      check("walk_entry", 64'(wr_entry), 64'd0);
      check("walk_target_we", 64'(target_we), 64'd0);
      check("walk_not_ready", 64'(table_ready), 64'd0);
    end
    @(negedge clk);
    check("walk_flush_done", 64'(flush_done), 64'd1);
    check("walk_table_ready", 64'(table_ready), 64'd1);
    @(negedge clk);
    check("walk_done_pulse", 64'(flush_done), 64'd0);

    // single update in RUN
    step();
    set_upd(5, 2, 32'h8000_1234);
    upd_valid = 1'b1;
    @(negedge clk);
    check("run_upd_ready", 64'(upd_ready), 64'd1);
    step();
    upd_valid = 1'b0;
    @(negedge clk);
    check("run_tag_we", 64'(tag_we), 64'h2);
    check("run_target_we", 64'(target_we), 64'h2);
    check("run_wr_addr", 64'(wr_addr), 64'd5);
    check("run_wr_target", 64'(wr_target), 64'h8000_1234);
    step();
    @(negedge clk);
    check("run_idle_we", 64'(tag_we), 64'd0);

    // backpressure while walking
    flush_pulse();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      set_upd(i + 1, (i % 2) ? 2 : 1, 32'h1000 + i);
      upd_valid = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        check("flush_wr_addr0", 64'(wr_addr), 64'd0);
        check("flush_not_ready", 64'(table_ready), 64'd0);
      end
      if (upd_ready) acc++;
    end
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_ready_low", 64'(upd_ready), 64'd0);
    step();
    upd_valid = 1'b0;
    wait_ready();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_order_addr", 64'(wr_addr), 64'(i + 1));
      check("bp_order_way", 64'(tag_we), 64'((i % 2) ? 2 : 1));
    end
    @(negedge clk);
    check("bp_drained", 64'(tag_we), 64'd0);
    check("bp_ready_back", 64'(upd_ready), 64'd1);

    // flush in the final walk cycle discards queued updates and the done pulse
    flush_pulse();
    upd_valid = 1'b1;
    set_upd(6, 1, 32'h2000);
    repeat (3) step();
    upd_valid = 1'b0;
    for (int k = 0; k < 20 && !(tag_we == 2'b11 && wr_addr == 3'd7); k++) @(negedge clk);
    check("last_walk_seen", 64'(wr_addr), 64'd7);
    flush_request = 1'b1;
    step();
    flush_request = 1'b0;
    @(negedge clk);
    check("last_restart_addr", 64'(wr_addr), 64'd0);
    check("last_no_done", 64'(flush_done), 64'd0);
    for (int i = 1; i < ENTRIES; i++) begin
      @(negedge clk);
      check("last_walk_addr", 64'(wr_addr), 64'(i));
      check("last_walk_no_done", 64'(flush_done), 64'd0);
    end
    @(negedge clk);
    check("last_done", 64'(flush_done), 64'd1);
    check("last_queue_gone", 64'(tag_we), 64'd0);

    // flush at walk index 5
    flush_pulse();
    for (int k = 0; k < 20 && wr_addr != 3'd5; k++) @(negedge clk);
    flush_request = 1'b1;
    step();
    flush_request = 1'b0;
    @(negedge clk);
    check("mid_restart_addr", 64'(wr_addr), 64'd0);
    for (int i = 1; i < ENTRIES; i++) begin
      @(negedge clk);
      check("mid_no_done", 64'(flush_done), 64'd0);
    end
    @(negedge clk);
    check("mid_done", 64'(flush_done), 64'd1);

    // reset while draining
    flush_pulse();
    upd_valid = 1'b1;
    set_upd(3, 2, 32'h3000);
    repeat (2) step();
    upd_valid = 1'b0;
    wait_ready();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rd_tag_we", 64'(tag_we), 64'd0);
    check("rd_upd_ready", 64'(upd_ready), 64'd0);
    check("rd_table_ready", 64'(table_ready), 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      check("rd_walk_addr", 64'(wr_addr), 64'(i));
    end
    @(negedge clk);
    check("rd_done", 64'(flush_done), 64'd1);
    check("rd_no_stale_write", 64'(tag_we), 64'd0);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      step();
      rst           = ($urandom_range(0, 299) != 0);
      flush_request = ($urandom_range(0, 59) == 0);
      upd_valid     = 1'($urandom_range(0, 1));
      upd_addr      = ADDR_W'($urandom);
      upd_way       = WAYS'($urandom_range(1, 3));
      upd_entry     = ENTRY_W'($urandom);
      upd_target_en = 1'($urandom_range(0, 1));
      upd_target    = $urandom;
    end
    step();
    rst = 1'b1; flush_request = 1'b0; upd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
